// File: rtl/blur_scheduler.sv
// Blur engine sequencer: accepts 5-tap windows, steps the engine through
// three phases and parks each result in a tagged one-deep output register.
module blur_scheduler #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   parameter int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [39:0]   in_pixels,
   output logic [39:0]   eng_pixels,
   output logic [1:0]    eng_phase,
   input  logic [7:0]    eng_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_pixel,
   output logic [CW-1:0] out_col,
   output logic [RW-1:0] out_row,
   output logic          busy,
   output logic          frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_IN,
      P1,
      P2,
      P3
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [39:0]   win;
   logic          capture;
   logic          last_col;
   logic          last_pix;

   assign last_col   = (col == CW'(WIDTH - 1));
   assign last_pix   = last_col && (row == RW'(HEIGHT - 1));
   assign eng_pixels = win;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      eng_phase = 2'd0;
      busy      = 1'b1;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nx = WAIT_IN;
            end
         end
         WAIT_IN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nx = P1;
            end
         end
         P1: begin
            eng_phase = 2'd1;
            state_nx  = P2;
         end
         P2: begin
            eng_phase = 2'd2;
            state_nx  = P3;
         end
         P3: begin
            eng_phase = 2'd3;
            // a pending result that the sink has not taken blocks capture
            if (!out_valid || out_ready) begin
               capture  = 1'b1;
               state_nx = last_pix ? IDLE : WAIT_IN;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         win        <= '0;
         out_valid  <= 1'b0;
         out_pixel  <= '0;
         out_col    <= '0;
         out_row    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= capture && last_pix;
         if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
         end
         if (state == WAIT_IN && in_valid) begin
            win <= in_pixels;
         end
         if (capture) begin
            out_valid <= 1'b1;
            out_pixel <= eng_result;
            out_col   <= col;
            out_row   <= row;
            if (last_pix) begin
               col <= '0;
               row <= '0;
            end else if (last_col) begin
               col <= '0;
               row <= row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
